udp_pktgen: RTL and testbench

UDP_PKTGEN -- requirements
Module: udp_pktgen

---
 rtl/eth_pkg.sv | 45 ++++
 rtl/ip_csum_calc.sv | 41 ++++
 rtl/udp_pktgen.sv | 207 ++++++++++++++++++++
 tb/tb_udp_pktgen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, header byte offsets, FSM state type and the
// ones'-complement adder for the UDP packet generator.
// Build option: UDP_PKTGEN_SEQNUM_EN (see udp_pktgen.sv).
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TOS         = 8'h00;
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

  localparam int unsigned OFF_ETH_DST   = 0;
  localparam int unsigned OFF_ETH_SRC   = 6;
  localparam int unsigned OFF_ETHTYPE   = 12;
  localparam int unsigned OFF_IP        = 14;
  localparam int unsigned OFF_IP_TOTLEN = 16;
  localparam int unsigned OFF_IP_ID     = 18;
  localparam int unsigned OFF_IP_FLAGS  = 20;
  localparam int unsigned OFF_IP_TTL    = 22;
  localparam int unsigned OFF_IP_PROTO  = 23;
  localparam int unsigned OFF_IP_CSUM   = 24;
  localparam int unsigned OFF_IP_SADDR  = 26;
  localparam int unsigned OFF_IP_DADDR  = 30;
  localparam int unsigned OFF_UDP_SPORT = 34;
  localparam int unsigned OFF_UDP_DPORT = 36;
  localparam int unsigned OFF_UDP_LEN   = 38;
  localparam int unsigned OFF_UDP_CSUM  = 40;
  localparam int unsigned HDR_LEN       = 42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_SEND,
    ST_GAP
  } state_t;

  // 16-bit ones'-complement addition with end-around carry
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_calc.sv
// IPv4 header checksum: combinational ones'-complement sum over the ten
// header words, captured into an output register when enabled.
module ip_csum_calc
  import eth_pkg::*;
#(
  parameter logic [31:0] IP_SADDR = 32'hC0A80B01,
  parameter logic [31:0] IP_DADDR = 32'hC0A80B03
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_ip_id,
  input  logic [15:0] i_total_len,
  output logic [15:0] o_csum
);

  logic [15:0] w_sum;

  // Sum of header words; the checksum field itself counts as zero
  always_comb begin
    w_sum = {IP_VER_IHL, IP_TOS};
    w_sum = ones_add(w_sum, i_total_len);
    w_sum = ones_add(w_sum, i_ip_id);
    w_sum = ones_add(w_sum, IP_FLAGS_DF);
    w_sum = ones_add(w_sum, {IP_TTL, IP_PROTO_UDP});
    w_sum = ones_add(w_sum, IP_SADDR[31:16]);
    w_sum = ones_add(w_sum, IP_SADDR[15:0]);
    w_sum = ones_add(w_sum, IP_DADDR[31:16]);
    w_sum = ones_add(w_sum, IP_DADDR[15:0]);
  end

  // Register the complemented sum so it is stable during transmission
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_csum <= '0;
    end else if (i_en) begin
      o_csum <= ~w_sum;
    end
  end

endmodule

// File: rtl/udp_pktgen.sv
// UDP/IPv4/Ethernet II frame generator on a 64-bit AXI-Stream master.
// Bursts of frame_count frames (0 = until stop), IFG_CYCLES idle cycles
// after each frame.
// Build option: define UDP_PKTGEN_SEQNUM_EN to place the per-burst frame
// sequence number (big-endian) in payload bytes 0..3.
module udp_pktgen
  import eth_pkg::*;
#(
  parameter logic [47:0] ETH_DST     = 48'h90E2BA5DD191,
  parameter logic [47:0] ETH_SRC     = 48'h001122334455,
  parameter logic [31:0] IP_SADDR    = 32'hC0A80B01,
  parameter logic [31:0] IP_DADDR    = 32'hC0A80B03,
  parameter logic [15:0] UDP_SPORT   = 16'h3776,
  parameter logic [15:0] UDP_DPORT   = 16'h3776,
  parameter int unsigned PAYLOAD_LEN = 18,
  parameter int unsigned IFG_CYCLES  = 16
) (
  input  logic        clk156,
  input  logic        eth_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] frame_count,
  output logic        busy,
  output logic [31:0] frames_sent,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
);

  localparam int unsigned FRAME_LEN = HDR_LEN + PAYLOAD_LEN;
  localparam int unsigned N_BEATS   = (FRAME_LEN + 7) / 8;
  localparam int unsigned LAST_REM  = FRAME_LEN % 8;
  localparam logic [7:0]  LAST_BEAT = 8'(N_BEATS - 1);
  localparam logic [7:0]  LAST_KEEP = (LAST_REM == 0) ? 8'hFF : 8'((1 << LAST_REM) - 1);
  localparam logic [15:0] IP_TOTLEN = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);
  localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_beat;
  logic [15:0] r_ip_id;
  logic [31:0] r_frames_sent;
  logic [31:0] r_burst_cnt;
  logic [31:0] r_frame_target;
  logic        r_stop;
  logic [15:0] r_gap_cnt;
  logic [15:0] w_csum;
  logic        w_hs, w_hs_last, w_gap_last, w_burst_done, w_csum_en;
  logic [7:0]  w_hdr [HDR_LEN];
  logic [63:0] w_beat_data;
  logic [15:0] w_k;
  logic [7:0]  w_byte;

  assign m_axis_tvalid = (r_state == ST_SEND);
  assign m_axis_tlast  = m_axis_tvalid && (r_beat == LAST_BEAT);
  assign m_axis_tkeep  = !m_axis_tvalid ? 8'h00 : (m_axis_tlast ? LAST_KEEP : 8'hFF);
  assign m_axis_tdata  = m_axis_tvalid ? w_beat_data : '0;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (r_state != ST_IDLE);
  assign frames_sent   = r_frames_sent;

  assign w_hs         = m_axis_tvalid && m_axis_tready;
  assign w_hs_last    = w_hs && m_axis_tlast;
  assign w_gap_last   = (IFG_CYCLES == 0) || (r_gap_cnt == GAP_LAST);
  assign w_burst_done = (r_frame_target != '0) && (r_burst_cnt >= r_frame_target);
  // Identification has already advanced when GAP is entered, so the
  // checksum computed in GAP belongs to the next frame.
  assign w_csum_en    = (r_state == ST_IDLE) || (r_state == ST_GAP);

  ip_csum_calc #(
    .IP_SADDR (IP_SADDR),
    .IP_DADDR (IP_DADDR)
  ) u_csum (
    .i_clk       (clk156),
    .i_rst_n     (eth_rst_n),
    .i_en        (w_csum_en),
    .i_ip_id     (r_ip_id),
    .i_total_len (IP_TOTLEN),
    .o_csum      (w_csum)
  );

  // Header bytes in wire order
  always_comb begin
    w_hdr = '{default: '0};
    for (int unsigned i = 0; i < 6; i++) begin
      w_hdr[OFF_ETH_DST + i] = ETH_DST[8*(5-i) +: 8];
      w_hdr[OFF_ETH_SRC + i] = ETH_SRC[8*(5-i) +: 8];
    end
    w_hdr[OFF_ETHTYPE]       = ETHERTYPE_IPV4[15:8];
    w_hdr[OFF_ETHTYPE + 1]   = ETHERTYPE_IPV4[7:0];
    w_hdr[OFF_IP]            = IP_VER_IHL;
    w_hdr[OFF_IP + 1]        = IP_TOS;
    w_hdr[OFF_IP_TOTLEN]     = IP_TOTLEN[15:8];
    w_hdr[OFF_IP_TOTLEN + 1] = IP_TOTLEN[7:0];
    w_hdr[OFF_IP_ID]         = r_ip_id[15:8];
    w_hdr[OFF_IP_ID + 1]     = r_ip_id[7:0];
    w_hdr[OFF_IP_FLAGS]      = IP_FLAGS_DF[15:8];
    w_hdr[OFF_IP_FLAGS + 1]  = IP_FLAGS_DF[7:0];
    w_hdr[OFF_IP_TTL]        = IP_TTL;
    w_hdr[OFF_IP_PROTO]      = IP_PROTO_UDP;
    w_hdr[OFF_IP_CSUM]       = w_csum[15:8];
    w_hdr[OFF_IP_CSUM + 1]   = w_csum[7:0];
    for (int unsigned i = 0; i < 4; i++) begin
      w_hdr[OFF_IP_SADDR + i] = IP_SADDR[8*(3-i) +: 8];
      w_hdr[OFF_IP_DADDR + i] = IP_DADDR[8*(3-i) +: 8];
    end
    w_hdr[OFF_UDP_SPORT]     = UDP_SPORT[15:8];
    w_hdr[OFF_UDP_SPORT + 1] = UDP_SPORT[7:0];
    w_hdr[OFF_UDP_DPORT]     = UDP_DPORT[15:8];
    w_hdr[OFF_UDP_DPORT + 1] = UDP_DPORT[7:0];
    w_hdr[OFF_UDP_LEN]       = UDP_LEN[15:8];
    w_hdr[OFF_UDP_LEN + 1]   = UDP_LEN[7:0];
    w_hdr[OFF_UDP_CSUM]      = 8'h00;
    w_hdr[OFF_UDP_CSUM + 1]  = 8'h00;
  end

  // Assemble the current beat: header, payload pattern, zero past frame end
  always_comb begin
    w_beat_data = '0;
    w_k         = '0;
    w_byte      = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      w_k    = {5'd0, r_beat, j[2:0]};
      w_byte = 8'h00;
      if (w_k < 16'(HDR_LEN)) begin
        w_byte = w_hdr[w_k[5:0]];
      end else if (w_k < 16'(FRAME_LEN)) begin
        w_byte = 8'(w_k - 16'(HDR_LEN));
`ifdef UDP_PKTGEN_SEQNUM_EN
        if (w_k < 16'(HDR_LEN + 4)) begin
          case (2'(w_k - 16'(HDR_LEN)))
            2'd0:    w_byte = r_burst_cnt[31:24];
            2'd1:    w_byte = r_burst_cnt[23:16];
            2'd2:    w_byte = r_burst_cnt[15:8];
            default: w_byte = r_burst_cnt[7:0];
          endcase
        end
`endif
      end
      w_beat_data[8*j +: 8] = w_byte;
    end
  end

  // State register
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_PREP;
      ST_PREP: w_next = ST_SEND;
      ST_SEND: if (w_hs_last) w_next = ST_GAP;
      ST_GAP:  if (w_gap_last) w_next = (w_burst_done || r_stop || stop) ? ST_IDLE : ST_PREP;
      default: w_next = ST_IDLE;
    endcase
  end

  // Beat index, counters, burst bookkeeping and stop latch
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_beat         <= '0;
      r_ip_id        <= '0;
      r_frames_sent  <= '0;
      r_burst_cnt    <= '0;
      r_frame_target <= '0;
      r_stop         <= 1'b0;
      r_gap_cnt      <= '0;
    end else begin
      if (r_state != ST_SEND) begin
        r_beat <= '0;
      end else if (w_hs) begin
        r_beat <= m_axis_tlast ? 8'd0 : r_beat + 8'd1;
      end

      if (w_hs_last) begin
        r_ip_id       <= r_ip_id + 16'd1;
        r_frames_sent <= r_frames_sent + 32'd1;
        r_burst_cnt   <= r_burst_cnt + 32'd1;
      end

      if (r_state == ST_IDLE) begin
        // stop alone is ignored here; stop together with start limits the
        // burst to one frame
        r_stop <= start && stop;
        if (start) begin
          r_burst_cnt    <= '0;
          r_frame_target <= frame_count;
        end
      end else if (stop) begin
        r_stop <= 1'b1;
      end

      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_udp_pktgen.sv
// Directed self-checking bench for udp_pktgen: three instances cover the
// default configuration, PAYLOAD_LEN=22/IFG_CYCLES=4 and IFG_CYCLES=0.
module tb_udp_pktgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  stop_v;
  logic [31:0] frame_count;
  logic        tready;

  logic        busy_a [3];
  logic [31:0] fs_a   [3];
  logic        v_a    [3];
  logic [63:0] d_a    [3];
  logic [7:0]  k_a    [3];
  logic        l_a    [3];
  logic        u_a    [3];

  int          sel;
  logic        mv, ml, mu;
  logic [63:0] md;
  logic [7:0]  mk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] cap_b [0:1599];
  logic [7:0] cap_k [0:199];
  int         cap_beats, cap_first, cap_end, cap_stall_bad;
  bit         cap_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_pktgen u0 (
    .clk156(clk), .eth_rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
    .frame_count(frame_count), .busy(busy_a[0]), .frames_sent(fs_a[0]),
    .m_axis_tready(tready), .m_axis_tvalid(v_a[0]), .m_axis_tdata(d_a[0]),
    .m_axis_tkeep(k_a[0]), .m_axis_tlast(l_a[0]), .m_axis_tuser(u_a[0])
  );

  udp_pktgen #(.PAYLOAD_LEN(22), .IFG_CYCLES(4)) u1 (
    .clk156(clk), .eth_rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
    .frame_count(frame_count), .busy(busy_a[1]), .frames_sent(fs_a[1]),
    .m_axis_tready(tready), .m_axis_tvalid(v_a[1]), .m_axis_tdata(d_a[1]),
    .m_axis_tkeep(k_a[1]), .m_axis_tlast(l_a[1]), .m_axis_tuser(u_a[1])
  );

  udp_pktgen #(.IFG_CYCLES(0)) u2 (
    .clk156(clk), .eth_rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]),
    .frame_count(frame_count), .busy(busy_a[2]), .frames_sent(fs_a[2]),
    .m_axis_tready(tready), .m_axis_tvalid(v_a[2]), .m_axis_tdata(d_a[2]),
    .m_axis_tkeep(k_a[2]), .m_axis_tlast(l_a[2]), .m_axis_tuser(u_a[2])
  );

  // Stream of the instance under test
  always_comb begin
    mv = v_a[sel];
    md = d_a[sel];
    mk = k_a[sel];
    ml = l_a[sel];
    mu = u_a[sel];
  end

  // Reference IPv4 header checksum for the default addresses
  function automatic logic [15:0] csum_ref(input logic [15:0] id, input logic [15:0] tot);
    int unsigned s;
    s = 32'h4500 + tot + id + 32'h4000 + 32'h4011 + 32'hC0A8 + 32'h0B01 + 32'hC0A8 + 32'h0B03;
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  // Reference frame byte k for the default header fields
  function automatic logic [7:0] exp_byte(input int k, input int plen,
                                          input logic [15:0] id, input logic [31:0] seq);
    logic [15:0] tot, ul, cs;
    int i;
    tot = 16'(28 + plen);
    ul  = 16'(8 + plen);
    cs  = csum_ref(id, tot);
    case (k)
      0: return 8'h90;  1: return 8'hE2;  2: return 8'hBA;  3: return 8'h5D;
      4: return 8'hD1;  5: return 8'h91;  6: return 8'h00;  7: return 8'h11;
      8: return 8'h22;  9: return 8'h33; 10: return 8'h44; 11: return 8'h55;
      12: return 8'h08; 13: return 8'h00; 14: return 8'h45; 15: return 8'h00;
      16: return tot[15:8]; 17: return tot[7:0];
      18: return id[15:8];  19: return id[7:0];
      20: return 8'h40; 21: return 8'h00; 22: return 8'h40; 23: return 8'h11;
      24: return cs[15:8];  25: return cs[7:0];
      26: return 8'hC0; 27: return 8'hA8; 28: return 8'h0B; 29: return 8'h01;
      30: return 8'hC0; 31: return 8'hA8; 32: return 8'h0B; 33: return 8'h03;
      34: return 8'h37; 35: return 8'h76; 36: return 8'h37; 37: return 8'h76;
      38: return ul[15:8];  39: return ul[7:0];
      40: return 8'h00; 41: return 8'h00;
      default: begin
        i = k - 42;
`ifdef UDP_PKTGEN_SEQNUM_EN
        if (i < 4) return seq[8*(3-i) +: 8];
`endif
        return (seq == 32'hFFFF_FFFF) ? 8'h00 : 8'(i);
      end
    endcase
  endfunction

  task automatic pulse_start(input int s, input bit with_stop);
    @(negedge clk);
    start_v[s] = 1'b1;
    stop_v[s]  = with_stop;
    @(negedge clk);
    start_v = '0;
    stop_v  = '0;
  endtask

  // Collect one frame from instance s; optionally stall and pulse stop
  task automatic capture(input int s, input bit toggle, input int stop_beat);
    bit          prev_st;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    sel = s;
    cap_beats = 0; cap_done = 0; cap_stall_bad = 0; cap_first = -1; cap_end = -1;
    prev_st = 0; pd = '0; pk = '0; pl = 1'b0;
    for (int t = 0; t < 3000 && !cap_done; t++) begin
      @(negedge clk);
      stop_v = '0;
      tready = toggle ? ~tready : 1'b1;
      if (stop_beat >= 0 && cap_beats == stop_beat && mv && tready) stop_v[s] = 1'b1;
      if (mv) begin
        if (prev_st && (md !== pd || mk !== pk || ml !== pl)) cap_stall_bad++;
        if (cap_first < 0) cap_first = cyc;
        if (tready && cap_beats < 190) begin
          for (int j = 0; j < 8; j++) cap_b[cap_beats*8 + j] = md[8*j +: 8];
          cap_k[cap_beats] = mk;
          cap_beats++;
          if (ml) begin
            cap_done = 1;
            cap_end  = cyc;
          end
        end
        prev_st = !tready;
        pd = md; pk = mk; pl = ml;
      end
    end
    stop_v = '0;
    tready = 1'b1;
  endtask

  task automatic wait_idle(input int s, output int n);
    n = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy_a[s]) begin
        n = t;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_v = '0; stop_v = '0; frame_count = '0; tready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    total++; if (v_a[0] !== 1'b0)   begin bad++; $display("FAIL rst_tvalid got=%b exp=0", v_a[0]); end
    total++; if (l_a[0] !== 1'b0)   begin bad++; $display("FAIL rst_tlast got=%b exp=0", l_a[0]); end
    total++; if (k_a[0] !== 8'h00)  begin bad++; $display("FAIL rst_tkeep got=%h exp=00", k_a[0]); end
    total++; if (d_a[0] !== 64'h0)  begin bad++; $display("FAIL rst_tdata got=%h exp=0", d_a[0]); end
    total++; if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a[0]); end
    total++; if (fs_a[0] !== 32'd0) begin bad++; $display("FAIL rst_frames_sent got=%0d exp=0", fs_a[0]); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int nerr, nk, n;
    frame_count = 32'd1;
    pulse_start(0, 1'b0);
    total++; if (busy_a[0] !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy_a[0]); end
    capture(0, 1'b0, -1);
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL single_timeout got=%b exp=1", cap_done); end
    total++; if (cap_beats !== 8) begin bad++; $display("FAIL single_beats got=%0d exp=8", cap_beats); end
    nk = 0;
    for (int b = 0; b < 7; b++) if (cap_k[b] !== 8'hFF) nk++;
    if (cap_k[7] !== 8'h0F) nk++;
    total++; if (nk !== 0) begin bad++; $display("FAIL single_tkeep got=%0d bad beats exp=0 (last=%h)", nk, cap_k[7]); end
    total++; if ({cap_b[16], cap_b[17]} !== 16'h002E) begin bad++; $display("FAIL single_totlen got=%h exp=002e", {cap_b[16], cap_b[17]}); end
    total++; if ({cap_b[24], cap_b[25]} !== 16'hA36A) begin bad++; $display("FAIL single_csum got=%h exp=a36a", {cap_b[24], cap_b[25]}); end
    nerr = 0;
    for (int k = 0; k < 60; k++) if (cap_b[k] !== exp_byte(k, 18, 16'd0, 32'd0)) nerr++;
    total++; if (nerr !== 0) begin bad++; $display("FAIL single_bytes got=%0d wrong bytes exp=0", nerr); end
    total++; if (mu !== 1'b0) begin bad++; $display("FAIL single_tuser got=%b exp=0", mu); end
    wait_idle(0, n);
    total++; if (n < 0) begin bad++; $display("FAIL single_idle_timeout got=%0d exp>=0", n); end
    total++; if (fs_a[0] !== 32'd1) begin bad++; $display("FAIL single_frames_sent got=%0d exp=1", fs_a[0]); end
  endtask

  task automatic test_stall;
    int nerr, n;
    frame_count = 32'd1;
    pulse_start(0, 1'b0);
    capture(0, 1'b1, -1);
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%b exp=1", cap_done); end
    total++; if (cap_stall_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d changes exp=0", cap_stall_bad); end
    total++; if (cap_beats !== 8) begin bad++; $display("FAIL stall_beats got=%0d exp=8", cap_beats); end
    total++; if ({cap_b[24], cap_b[25]} !== 16'hA369) begin bad++; $display("FAIL stall_csum got=%h exp=a369", {cap_b[24], cap_b[25]}); end
    nerr = 0;
    for (int k = 0; k < 60; k++) if (cap_b[k] !== exp_byte(k, 18, 16'd1, 32'd0)) nerr++;
    total++; if (nerr !== 0) begin bad++; $display("FAIL stall_bytes got=%0d wrong bytes exp=0", nerr); end
    wait_idle(0, n);
    total++; if (fs_a[0] !== 32'd2) begin bad++; $display("FAIL stall_frames_sent got=%0d exp=2", fs_a[0]); end
  endtask

  task automatic test_burst;
    int prev_end, nerr, nb;
    frame_count = 32'd3;
    pulse_start(1, 1'b0);
    prev_end = -1;
    for (int f = 0; f < 3; f++) begin
      capture(1, 1'b0, -1);
      total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL burst_timeout f=%0d got=%b exp=1", f, cap_done); end
      total++; if ({cap_b[18], cap_b[19]} !== 16'(f)) begin bad++; $display("FAIL burst_id f=%0d got=%h exp=%0d", f, {cap_b[18], cap_b[19]}, f); end
      total++; if (cap_beats !== 8 || cap_k[7] !== 8'hFF) begin bad++; $display("FAIL burst_last_keep f=%0d got beats=%0d keep=%h exp 8/ff", f, cap_beats, cap_k[7]); end
      nerr = 0;
      for (int k = 0; k < 64; k++) if (cap_b[k] !== exp_byte(k, 22, 16'(f), 32'(f))) nerr++;
      total++; if (nerr !== 0) begin bad++; $display("FAIL burst_bytes f=%0d got=%0d wrong bytes exp=0", f, nerr); end
      if (f > 0) begin
        total++; if (cap_first - prev_end - 1 !== 5) begin bad++; $display("FAIL burst_gap f=%0d got=%0d exp=5", f, cap_first - prev_end - 1); end
      end
      prev_end = cap_end;
    end
    nb = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy_a[1]) break;
      nb++;
    end
    total++; if (nb !== 4) begin bad++; $display("FAIL burst_busy_tail got=%0d exp=4", nb); end
    total++; if (fs_a[1] !== 32'd3) begin bad++; $display("FAIL burst_frames_sent got=%0d exp=3", fs_a[1]); end
  endtask

  task automatic test_stop;
    int first1, nv, n;
    frame_count = 32'd0;
    pulse_start(2, 1'b0);
    capture(2, 1'b0, -1);
    first1 = cap_first;
    capture(2, 1'b0, 3);
    total++; if (cap_done !== 1'b1 || cap_beats !== 8) begin bad++; $display("FAIL stop_frame2 got done=%b beats=%0d exp 1/8", cap_done, cap_beats); end
    total++; if ({cap_b[18], cap_b[19]} !== 16'd1) begin bad++; $display("FAIL stop_id got=%h exp=0001", {cap_b[18], cap_b[19]}); end
    total++; if (cap_first - first1 !== 10) begin bad++; $display("FAIL stop_spacing got=%0d exp=10", cap_first - first1); end
    nv = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (mv) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL stop_no_frame3 got=%0d valid cycles exp=0", nv); end
    wait_idle(2, n);
    total++; if (n !== 0) begin bad++; $display("FAIL stop_busy got=%0d exp=0", n); end
    total++; if (fs_a[2] !== 32'd2) begin bad++; $display("FAIL stop_frames_sent got=%0d exp=2", fs_a[2]); end
  endtask

  task automatic test_start_stop;
    int nv;
    frame_count = 32'd0;
    pulse_start(2, 1'b1);
    capture(2, 1'b0, -1);
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL startstop_timeout got=%b exp=1", cap_done); end
    nv = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (mv) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL startstop_extra got=%0d valid cycles exp=0", nv); end
    total++; if (fs_a[2] !== 32'd3) begin bad++; $display("FAIL startstop_frames_sent got=%0d exp=3", fs_a[2]); end
  endtask

  task automatic test_reset_mid;
    int  nh;
    bit  hit;
    frame_count = 32'd1;
    pulse_start(0, 1'b0);
    sel = 0; nh = 0; hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      if (mv) begin
        if (nh == 3) begin
          rst_n = 1'b0;
          hit = 1;
        end else begin
          nh++;
        end
      end
    end
    #1;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_beat3 got=%b exp=1", hit); end
    total++; if (mv !== 1'b0 || md !== 64'h0) begin bad++; $display("FAIL rstmid_tvalid got=%b data=%h exp 0/0", mv, md); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(0, 1'b0);
    capture(0, 1'b0, -1);
    total++; if ({cap_b[18], cap_b[19]} !== 16'd0 || {cap_b[24], cap_b[25]} !== 16'hA36A) begin
      bad++; $display("FAIL rstmid_id got id=%h csum=%h exp 0000/a36a", {cap_b[18], cap_b[19]}, {cap_b[24], cap_b[25]});
    end
    @(negedge clk);
    total++; if (fs_a[0] !== 32'd1) begin bad++; $display("FAIL rstmid_frames_sent got=%0d exp=1", fs_a[0]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_burst;
    test_stop;
    test_start_stop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
